// File: rtl/input_debounce_if.sv
// Raw board inputs and debounced outputs between the board pins and the processor top.
// The master side drives the raw levels; the slave side is the debouncer.
interface input_debounce_if #(
  parameter int NSW = 8
) ();
  logic [NSW-1:0] switches_raw;
  logic           btn_raw;
  logic [NSW-1:0] switches;
  logic           btn_level;
  logic           step_pulse;
  logic           sw_changed;

  modport master (
    output switches_raw, btn_raw,
    input  switches, btn_level, step_pulse, sw_changed
  );

  modport slave (
    input  switches_raw, btn_raw,
    output switches, btn_level, step_pulse, sw_changed
  );
endinterface

// File: rtl/input_debounce.sv
// Synchronizes and debounces NSW DIP switches plus one pushbutton.
// It also produces single-cycle pulses for button presses and for switch changes.
module input_debounce #(
  parameter int NSW       = 8,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input logic              clk,
  input logic              reset,
  input_debounce_if.slave  dbi
);
  localparam int NCH = NSW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NCH-1:0] raw_w;
  logic [NCH-1:0] stable_w;

  // The button occupies the top channel; the switches occupy the channels below it.
  assign raw_w = {dbi.btn_raw, dbi.switches_raw};

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic             s1_q;
      logic             s2_q;
      logic             stable_q;
      logic             stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Any sample that matches the stable level restarts the count, so a bounce never accumulates.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= raw_w[gi];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable_w[gi] = stable_q;
    end
  endgenerate

  logic [NSW-1:0] sw_prev_q;
  logic           btn_prev_q;
  logic           step_pulse_q;
  logic           step_pulse_d;
  logic           sw_changed_q;
  logic           sw_changed_d;

  always_comb begin
    step_pulse_d = stable_w[NSW] & ~btn_prev_q;
    sw_changed_d = |(stable_w[NSW-1:0] ^ sw_prev_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_prev_q    <= '0;
      btn_prev_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_prev_q    <= stable_w[NSW-1:0];
      btn_prev_q   <= stable_w[NSW];
      step_pulse_q <= step_pulse_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign dbi.switches   = stable_w[NSW-1:0];
  assign dbi.btn_level  = stable_w[NSW];
  assign dbi.step_pulse = step_pulse_q;
  assign dbi.sw_changed = sw_changed_q;
endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: scheduled output events are queued when stimulus is driven.
// All four outputs are then compared on every falling clock edge.
module tb_input_debounce;
  localparam int NSW = 8;
  localparam int DBC = 4;
  localparam int CW  = 3;
  localparam int LAT = 2 + DBC;

  localparam int K_SW   = 0;
  localparam int K_BTN  = 1;
  localparam int K_STEP = 2;
  localparam int K_CHG  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  input_debounce_if #(.NSW(NSW)) dbi ();

  input_debounce #(.NSW(NSW), .DB_CYCLES(DBC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .dbi   (dbi)
  );

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_sw  = 8'h00;
  logic       exp_btn = 1'b0;

  function automatic void push(input int c, input int kind, input logic [7:0] v);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.kind = kind;
    e.val  = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    logic exp_step;
    logic exp_chg;
    ev_t  e;
    exp_step = 1'b0;
    exp_chg  = 1'b0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_SW:    exp_sw   = e.val;
        K_BTN:   exp_btn  = e.val[0];
        K_STEP:  exp_step = 1'b1;
        default: exp_chg  = 1'b1;
      endcase
      $display("event cyc=%0d kind=%0d val=%h", cyc, e.kind, e.val);
    end
    chk("switches",   dbi.switches,          exp_sw);
    chk("btn_level",  {7'd0, dbi.btn_level}, {7'd0, exp_btn});
    chk("step_pulse", {7'd0, dbi.step_pulse}, {7'd0, exp_step});
    chk("sw_changed", {7'd0, dbi.sw_changed}, {7'd0, exp_chg});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  // Raw inputs are changed just after an edge, so the next edge samples them into the first synchronizer flop.
  task automatic drive_sw(input logic [7:0] v);
    dbi.switches_raw = v;
    push(cyc + LAT, K_SW, v);
    push(cyc + LAT + 1, K_CHG, 8'h00);
  endtask

  initial begin
    dbi.switches_raw = 8'hFF;
    dbi.btn_raw      = 1'b1;
    reset            = 1'b1;
    ticks(3);

    // Inputs already high at reset release: one pulse of each kind.
    reset = 1'b0;
    push(cyc + LAT, K_SW, 8'hFF);
    push(cyc + LAT, K_BTN, 8'h01);
    push(cyc + LAT + 1, K_STEP, 8'h00);
    push(cyc + LAT + 1, K_CHG, 8'h00);
    ticks(10);

    dbi.btn_raw = 1'b0;
    push(cyc + LAT, K_BTN, 8'h00);
    drive_sw(8'h00);
    ticks(10);

    drive_sw(8'h05);
    ticks(10);

    // Bit 3 bounces with 2-cycle periods before settling high.
    dbi.switches_raw = 8'h0D; ticks(2);
    dbi.switches_raw = 8'h05; ticks(2);
    dbi.switches_raw = 8'h0D; ticks(2);
    dbi.switches_raw = 8'h05; ticks(2);
    drive_sw(8'h0D);
    ticks(10);

    dbi.btn_raw = 1'b1;
    push(cyc + LAT, K_BTN, 8'h01);
    push(cyc + LAT + 1, K_STEP, 8'h00);
    ticks(50);
    dbi.btn_raw = 1'b0;
    push(cyc + LAT, K_BTN, 8'h00);
    ticks(10);

    drive_sw(8'h0C);
    ticks(10);
    dbi.btn_raw = 1'b1;
    push(cyc + LAT, K_BTN, 8'h01);
    push(cyc + LAT + 1, K_STEP, 8'h00);
    drive_sw(8'h0D);
    ticks(10);
    dbi.btn_raw = 1'b0;
    push(cyc + LAT, K_BTN, 8'h00);
    ticks(10);

    // Reset lands two counts into a bit-1 rise; nothing is queued for that rise.
    dbi.switches_raw = 8'h0F;
    ticks(4);
    #2;
    reset   = 1'b1;
    exp_sw  = 8'h00;
    exp_btn = 1'b0;
    #1;
    chk("async_rst_sw",   dbi.switches,           8'h00);
    chk("async_rst_btn",  {7'd0, dbi.btn_level},  8'h00);
    chk("async_rst_step", {7'd0, dbi.step_pulse}, 8'h00);
    chk("async_rst_chg",  {7'd0, dbi.sw_changed}, 8'h00);
    ticks(3);
    reset = 1'b0;
    push(cyc + LAT, K_SW, 8'h0F);
    push(cyc + LAT + 1, K_CHG, 8'h00);
    ticks(10);

    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Input-side counterpart to the seven-segment display path.
- Takes raw board DIP switches and the pushbutton, which are asynchronous and bouncy, and brings them into the 100 MHz `clk` domain through 2-FF synchronizers.
- Debounces each channel with its own counter and presents stable levels to the processor top: register-select bits and display-mode bits.
- Also outputs single-cycle event pulses: a button step pulse and a switch-change pulse.

Parameters:
- NSW, 8, number of switch channels.
- DB_CYCLES, 500000, clk cycles an input must hold a new value before it is accepted (5 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, 20, width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  reset, asynchronous, active-high; the block uses one clock only.
- switches_raw  input  NSW  raw DIP switch levels, asynchronous to clk.
- btn_raw  input  1  raw pushbutton level, asynchronous, 1 = pressed.
- switches  output  NSW  debounced switch levels.
- btn_level  output  1  debounced button level.
- step_pulse  output  1  one-cycle pulse on each debounced button press (0->1).
- sw_changed  output  1  one-cycle pulse when any bit of `switches` changes.

Behaviour:
- Channels: NSW switch channels plus 1 button channel, all identical and fully independent.
- Synchronizer:
  - Two flops per channel: s1 <= raw; s2 <= s1.
  - s2 is the only signal used by the debounce logic.
- Per-channel debounce, with state held in `stable` and `cnt`:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Bounce handling: a glitch that returns s2 to `stable` before the count completes clears cnt, and `stable` does not move.
- Latency: a clean raw transition appears on the output exactly 2 + DB_CYCLES clk edges after the first edge that samples it into s1.
- Output mapping: `switches` = stable of the switch channels; `btn_level` = stable of the button channel.
- step_pulse:
  - Registered; high for the single cycle after btn_level goes 0->1.
  - No pulse on release.
  - Holding the button gives exactly one pulse; there is no auto-repeat.
- sw_changed:
  - Registered; high for one cycle after any switch stable bit updates.
  - Several bits updating on the same edge produce one pulse.
  - Updates on consecutive cycles produce consecutive pulses.
- Simultaneous events: button and switch updates on the same edge assert step_pulse and sw_changed together in the same cycle.
- Reset (asserted asynchronously, at any time, including mid-count):
  - Clears s1, s2, stable, cnt, the step_pulse register, the sw_changed register and the previous-level registers.
  - All outputs read 0 while reset is high.
- Release from reset with inputs already high: the normal debounce applies, so the outputs rise 2 + DB_CYCLES cycles later.
  - step_pulse fires if the button is held through reset.
  - sw_changed fires once if any switch is high.
- Counter saturation: cnt never exceeds DB_CYCLES-1, so no wrap-around is possible.

Test Plan (DB_CYCLES=4, NSW=8):
- Reset: hold reset with switches_raw=8'hFF and btn_raw=1 -> all outputs 0. Release reset -> switches=8'hFF after 6 edges, with exactly one sw_changed pulse and one step_pulse.
- Clean switch change: switches_raw 8'h00->8'h05 -> switches=8'h05 on edge 6, sw_changed high for 1 cycle only, step_pulse stays 0.
- Bounce rejection: toggle switches_raw[3] 1,0,1,0 with 2-cycle periods, then hold 1 -> no output change during the bouncing. switches[3]=1 exactly 6 edges after the final rise; a single sw_changed pulse.
- Button press and hold: btn_raw=1 for 50 cycles, then 0 -> one step_pulse 6 edges after the press, none on release. btn_level falls 6 edges after release.
- Simultaneous: btn_raw and switches_raw[0] rise on the same cycle -> step_pulse and sw_changed asserted in the same cycle.
- Reset mid-operation: assert reset 2 cycles into a count -> outputs 0 immediately (asynchronously). Release reset -> a full 2+4 cycle count restarts; there is no early update.
